// File: rtl/sumador_pkg.sv
// Shared types and constants for the bit-serial add/subtract unit feeding the
// seven-segment display driver.
package sumador_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int RES_W = 8;

endpackage

// File: rtl/serial_adder_7seg_src_if.sv
// Operation request / result bundle between the requester and the serial adder.
interface serial_adder_7seg_src_if
  import sumador_pkg::*;
#(
  parameter int WIDTH = 4
);

  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [RES_W-1:0] num;
  logic             busy;
  logic             done;

  modport master (output start, op, a, b, input num, busy, done);
  modport slave  (input start, op, a, b, output num, busy, done);

endinterface

// File: rtl/full_adder_1b.sv
// One-bit full adder used as the single arithmetic cell of the serial datapath.
module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_7seg_src.sv
// Bit-serial add/subtract, one operand bit per clock; the finished result is
// held on num for the seven-segment driver until the next operation completes.
module serial_adder_7seg_src
  import sumador_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  serial_adder_7seg_src_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t           state_reg, state_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  logic [WIDTH-1:0] a_sr_reg, b_sr_reg, res_sr_reg;
  logic             op_reg, carry_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [RES_W-1:0] num_reg, num_next;

  logic             b_eff, fa_s, fa_cout, last_bit, top_bit;
  logic [WIDTH:0]   res_wide;
  logic [WIDTH-1:0] res_shift;

  // Subtraction is a + ~b + 1: invert b bit-wise here, the +1 is the initial carry.
  assign b_eff = b_sr_reg[0] ^ op_reg;

  full_adder_1b u_fa (
    .a    (a_sr_reg[0]),
    .b    (b_eff),
    .cin  (carry_reg),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign last_bit  = (cnt_reg == CNT_W'(WIDTH - 1));
  assign res_wide  = {fa_s, res_sr_reg};
  assign res_shift = res_wide[WIDTH:1];
  // For subtraction a missing final carry means a borrow, i.e. a negative result.
  assign top_bit   = (op_reg == OP_SUB) ? ~fa_cout : fa_cout;

  // Result bits, then the carry/sign bit, then zero- or sign-extension.
  generate
    for (genvar gi = 0; gi < RES_W; gi++) begin : g_num
      if (gi < WIDTH) begin : g_res
        assign num_next[gi] = res_shift[gi];
      end else if (gi == WIDTH) begin : g_top
        assign num_next[gi] = top_bit;
      end else begin : g_ext
        assign num_next[gi] = (op_reg == OP_SUB) & top_bit;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (last_bit)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Flags are decoded from the next state so they are registered like num.
  always_comb begin
    busy_next = (state_next != IDLE);
    done_next = (state_next == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr_reg   <= '0;
      b_sr_reg   <= '0;
      res_sr_reg <= '0;
      op_reg     <= OP_ADD;
      carry_reg  <= 1'b0;
      cnt_reg    <= '0;
      num_reg    <= '0;
    end else if (state_reg == IDLE) begin
      if (bus.start) begin
        a_sr_reg   <= bus.a;
        b_sr_reg   <= bus.b;
        res_sr_reg <= '0;
        op_reg     <= bus.op;
        carry_reg  <= bus.op;
        cnt_reg    <= '0;
      end
    end else if (state_reg == SHIFT) begin
      a_sr_reg   <= a_sr_reg >> 1;
      b_sr_reg   <= b_sr_reg >> 1;
      res_sr_reg <= res_shift;
      carry_reg  <= fa_cout;
      cnt_reg    <= cnt_reg + CNT_W'(1);
      if (last_bit) begin
        num_reg <= num_next;
      end
    end
  end

  assign bus.num  = num_reg;
  assign bus.busy = busy_reg;
  assign bus.done = done_reg;

endmodule

// File: tb/tb_serial_adder_7seg_src.sv
// Randomized and directed checks of the serial adder against an arithmetic model,
// with a done-triggered scoreboard monitor.
module tb_serial_adder_7seg_src;
  import sumador_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  serial_adder_7seg_src_if #(.WIDTH(W)) bus ();

  serial_adder_7seg_src #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_q[$];
  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] shown       = 8'h00;

  function automatic logic [7:0] model(input int a, input int b, input logic o);
    int r;
    r = (o == OP_SUB) ? (a - b) : (a + b);
    return 8'(r);
  endfunction

  task automatic check(input string name, input int actual, input int required);
    vectors++;
    if (actual != required) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, actual, required);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (exp_q.size() == 0) begin
        check("done without request", 1, 0);
      end else begin
        check("num", int'(bus.num), int'(exp_q.pop_front()));
        $display("result num=%02h", bus.num);
      end
    end
  end

  // Issue one operation at a negedge; optionally scramble inputs while it runs.
  task automatic run_op(input int aa, input int bb, input logic o, input bit scramble);
    logic [7:0] e;
    int busy_cnt, done_cnt, done_k;
    e = model(aa, bb, o);
    exp_q.push_back(e);
    $display("op a=%0h b=%0h op=%0d expect=%02h", aa, bb, o, e);
    bus.a = W'(aa); bus.b = W'(bb); bus.op = o; bus.start = 1'b1;
    busy_cnt = 0; done_cnt = 0; done_k = -1;
    for (int k = 1; k <= W + 3; k++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (k == W) check("num stale mid-op", int'(bus.num), int'(shown));
      if (scramble && k <= W + 1) begin
        bus.a = W'($urandom); bus.b = W'($urandom);
        bus.op = 1'($urandom); bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
    end
    check("done latency", done_k, W + 1);
    check("done count", done_cnt, 1);
    check("busy cycles", busy_cnt, W + 1);
    shown = e;
  endtask

  initial begin
    int dk[3];
    int dn, bad;
    bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(negedge clk);
    check("reset num", int'(bus.num), 0);
    check("reset busy", int'(bus.busy), 0);
    check("reset done", int'(bus.done), 0);
    rst = 1'b0;

    run_op(4'hF, 4'h5, OP_ADD, 1'b0);
    run_op(4'h3, 4'h5, OP_SUB, 1'b0);
    run_op(4'h9, 4'h2, OP_SUB, 1'b0);
    run_op(4'h1, 4'h1, OP_ADD, 1'b1);

    // start held high: back-to-back operations every W+2 edges.
    for (int i = 0; i < 3; i++) exp_q.push_back(model(2, 3, OP_ADD));
    bus.a = 4'h2; bus.b = 4'h3; bus.op = OP_ADD; bus.start = 1'b1;
    dn = 0; dk = '{-1, -1, -1};
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (bus.done) begin
        if (dn < 3) dk[dn] = k;
        dn++;
      end
      if (k == 13) bus.start = 1'b0;
    end
    check("held start done count", dn, 3);
    check("held start first done", dk[0], W + 1);
    check("held start spacing 1", dk[1] - dk[0], W + 2);
    check("held start spacing 2", dk[2] - dk[1], W + 2);
    check("held start num", int'(bus.num), 8'h05);
    shown = 8'h05;

    // Reset in the middle of F+F after a prior result of 14.
    run_op(4'hF, 4'h5, OP_ADD, 1'b0);
    bus.a = 4'hF; bus.b = 4'hF; bus.op = OP_ADD; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async reset num", int'(bus.num), 0);
    check("async reset busy", int'(bus.busy), 0);
    check("async reset done", int'(bus.done), 0);
    @(negedge clk);
    rst = 1'b0;
    shown = 8'h00;
    run_op(4'h1, 4'h1, OP_ADD, 1'b0);

    run_op(4'h0, 4'h0, OP_ADD, 1'b0);

    // Display hookup: a negative result must hold through idle input noise.
    run_op(4'h2, 4'hE, OP_SUB, 1'b0);
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      bus.a = W'($urandom); bus.b = W'($urandom); bus.op = 1'($urandom);
      @(negedge clk);
      if (bus.num != 8'hF4 || bus.busy || bus.done) bad++;
    end
    check("num held 1000 cycles", bad, 0);

    for (int i = 0; i < 30; i++) begin
      run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check("scoreboard drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
